// File: rtl/issue_ctrl_if.sv
// issue_ctrl_if: decoder -> issue -> execute/memory signal bundle for issue_ctrl
interface issue_ctrl_if #(
    parameter int STALL_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [26:0]        in_instr;
    logic [3:0]         dec_ra_a;
    logic [3:0]         dec_ra_b;
    logic [3:0]         dec_ra_m;
    logic [3:0]         dec_ra_d;
    logic               dec_is_mem;
    logic               dec_is_jump;
    logic               dec_priv;
    logic               priv_in;
    logic               out_valid;
    logic               out_ready;
    logic [26:0]        out_instr;
    logic [3:0]         out_ra_a;
    logic [3:0]         out_ra_b;
    logic [3:0]         out_ra_m;
    logic [3:0]         out_ra_d;
    logic               out_is_mem;
    logic               out_is_jump;
    logic               wb_valid;
    logic [3:0]         wb_addr;
    logic               mem_done;
    logic               redirect;
    logic               fault;
    logic [26:0]        fault_instr;
    logic               fault_ack;
    logic [STALL_W-1:0] stall_cnt;

    modport slave (
        input  in_valid, in_instr, dec_ra_a, dec_ra_b, dec_ra_m, dec_ra_d,
               dec_is_mem, dec_is_jump, dec_priv, priv_in, out_ready,
               wb_valid, wb_addr, mem_done, redirect, fault_ack,
        output in_ready, out_valid, out_instr, out_ra_a, out_ra_b, out_ra_m,
               out_ra_d, out_is_mem, out_is_jump, fault, fault_instr, stall_cnt
    );

    modport master (
        output in_valid, in_instr, dec_ra_a, dec_ra_b, dec_ra_m, dec_ra_d,
               dec_is_mem, dec_is_jump, dec_priv, priv_in, out_ready,
               wb_valid, wb_addr, mem_done, redirect, fault_ack,
        input  in_ready, out_valid, out_instr, out_ra_a, out_ra_b, out_ra_m,
               out_ra_d, out_is_mem, out_is_jump, fault, fault_instr, stall_cnt
    );
endinterface

// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order issue register with 16-entry write scoreboard, memory-port and jump interlocks, privilege trap
module issue_ctrl #(
    parameter int STALL_W = 16
) (
    input logic         clk,
    input logic         rst_n,
    issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, JWAIT, FAULT} state_t;
    typedef struct packed {
        logic [26:0] instr;
        logic [3:0]  ra_a;
        logic [3:0]  ra_b;
        logic [3:0]  ra_m;
        logic [3:0]  ra_d;
        logic        is_mem;
        logic        is_jump;
    } slot_t;

    state_t             state_q, state_d;
    slot_t              slot_q, slot_d, slot_in;
    logic [15:0]        pend_q, pend_d, eff, wb_mask, set_mask;
    logic               mem_busy_q, mem_busy_d;
    logic               out_valid_q, out_valid_d;
    logic [26:0]        fault_instr_q, fault_instr_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               hazard, slot_free, viol, ready, accept, issue, trap;

    assign slot_in = '{instr: bus.in_instr, ra_a: bus.dec_ra_a, ra_b: bus.dec_ra_b,
                       ra_m: bus.dec_ra_m, ra_d: bus.dec_ra_d,
                       is_mem: bus.dec_is_mem, is_jump: bus.dec_is_jump};

    // pend bit 0 is never set, so a zero address can never report a hazard
    assign wb_mask   = bus.wb_valid ? (16'b1 << bus.wb_addr) : 16'b0;
    assign eff       = pend_q & ~wb_mask;
    assign hazard    = eff[bus.dec_ra_a] | eff[bus.dec_ra_b] | eff[bus.dec_ra_m] | eff[bus.dec_ra_d];
    assign slot_free = !out_valid_q | bus.out_ready;
    assign viol      = bus.dec_priv & ~bus.priv_in;
    assign ready     = (state_q == RUN) & slot_free & (viol | (!hazard & !(bus.dec_is_mem & mem_busy_q)));
    assign accept    = bus.in_valid & ready;
    assign issue     = accept & !viol;
    assign trap      = accept & viol;
    assign set_mask  = (issue && bus.dec_ra_d != 4'd0) ? (16'b1 << bus.dec_ra_d) : 16'b0;

    always_comb begin
        state_d = state_q;
        if (trap)
            state_d = FAULT;
        else if (issue && bus.dec_is_jump)
            state_d = JWAIT;
        else if ((state_q == JWAIT && bus.redirect) || (state_q == FAULT && bus.fault_ack))
            state_d = RUN;
        pend_d        = eff | set_mask;
        mem_busy_d    = (issue & bus.dec_is_mem) | (mem_busy_q & !bus.mem_done);
        out_valid_d   = issue | (out_valid_q & !bus.out_ready);
        slot_d        = issue ? slot_in : slot_q;
        fault_instr_d = trap ? bus.in_instr : fault_instr_q;
        stall_d       = (bus.in_valid && !ready && !(&stall_q)) ? stall_q + STALL_W'(1) : stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            slot_q        <= '0;
            pend_q        <= '0;
            mem_busy_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            fault_instr_q <= '0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            pend_q        <= pend_d;
            mem_busy_q    <= mem_busy_d;
            out_valid_q   <= out_valid_d;
            fault_instr_q <= fault_instr_d;
            stall_q       <= stall_d;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = slot_q.instr;
    assign bus.out_ra_a    = slot_q.ra_a;
    assign bus.out_ra_b    = slot_q.ra_b;
    assign bus.out_ra_m    = slot_q.ra_m;
    assign bus.out_ra_d    = slot_q.ra_d;
    assign bus.out_is_mem  = slot_q.is_mem;
    assign bus.out_is_jump = slot_q.is_jump;
    assign bus.fault       = (state_q == FAULT);
    assign bus.fault_instr = fault_instr_q;
    assign bus.stall_cnt   = stall_q;
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed scenarios plus randomized traffic against a transaction-level model
module tb_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    issue_ctrl_if #(.STALL_W(16)) bus ();
    issue_ctrl #(.STALL_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] instr;
        logic [3:0]  a, b, m, d;
        logic        mem, jump;
    } rec_t;

    rec_t        held[$];
    logic        pend_m[16];
    logic        busy_m, jwait_m, fault_m;
    logic [26:0] finstr_m;
    int          stall_m;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_instr = '0;
        bus.dec_ra_a = 0; bus.dec_ra_b = 0; bus.dec_ra_m = 0; bus.dec_ra_d = 0;
        bus.dec_is_mem = 0; bus.dec_is_jump = 0; bus.dec_priv = 0;
        bus.wb_valid = 0; bus.wb_addr = 0; bus.mem_done = 0; bus.redirect = 0; bus.fault_ack = 0;
        #1;
    endtask

    task automatic offer(input logic [26:0] instr, input logic [3:0] a, b, m, d,
                         input logic mem, jump, priv);
        bus.in_valid = 1; bus.in_instr = instr;
        bus.dec_ra_a = a; bus.dec_ra_b = b; bus.dec_ra_m = m; bus.dec_ra_d = d;
        bus.dec_is_mem = mem; bus.dec_is_jump = jump; bus.dec_priv = priv;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        bus.out_ready = 1; bus.priv_in = 0;
        #2;
        rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        bus.out_ready = 1; bus.priv_in = 0;
        #2;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %0b want 0", bus.fault); end
        n_cmp++; if (bus.out_instr !== 27'h0 || bus.out_ra_d !== 4'h0 || bus.out_is_mem !== 1'b0) begin n_bad++; $display("FAIL rst_out_fields: got %0h/%0h/%0b want 0", bus.out_instr, bus.out_ra_d, bus.out_is_mem); end
        n_cmp++; if (bus.fault_instr !== 27'h0) begin n_bad++; $display("FAIL rst_fault_instr: got %0h want 0", bus.fault_instr); end
        n_cmp++; if (bus.stall_cnt !== 16'h0) begin n_bad++; $display("FAIL rst_stall: got %0h want 0", bus.stall_cnt); end
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic test_alu();
        for (int i = 1; i <= 4; i++) begin
            offer(27'(i * 'h111), 0, 0, 0, 4'(i), 0, 0, 0);
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL alu_ready%0d: got %0b want 1", i, bus.in_ready); end
            if (i > 1) begin
                n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_ra_d !== 4'(i - 1)) begin n_bad++; $display("FAIL alu_out%0d: got v=%0b d=%0d want v=1 d=%0d", i, bus.out_valid, bus.out_ra_d, i - 1); end
            end
            step();
        end
        idle();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_ra_d !== 4'd4 || bus.out_instr !== 27'h444) begin n_bad++; $display("FAIL alu_last: got v=%0b d=%0d i=%0h want v=1 d=4 i=444", bus.out_valid, bus.out_ra_d, bus.out_instr); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL alu_drain: got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL alu_stall: got %0d want 0", bus.stall_cnt); end
        for (int r = 1; r <= 5; r++) begin
            offer(27'h7, 4'(r), 0, 0, 0, 0, 0, 0);
            n_cmp++; if (bus.in_ready !== (r == 5)) begin n_bad++; $display("FAIL alu_pend%0d: got ready %0b want %0b", r, bus.in_ready, r == 5); end
        end
        idle();
        for (int r = 1; r <= 4; r++) begin
            bus.wb_valid = 1; bus.wb_addr = 4'(r);
            step();
        end
        idle();
    endtask

    task automatic test_raw();
        offer(27'h55, 0, 0, 0, 5, 0, 0, 0);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL raw_prod: got %0b want 1", bus.in_ready); end
        step();
        offer(27'h56, 5, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall%0d: got %0b want 0", k, bus.in_ready); end
            step();
        end
        bus.wb_valid = 1; bus.wb_addr = 5;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL raw_bypass: got %0b want 1", bus.in_ready); end
        step();
        idle();
        n_cmp++; if (bus.stall_cnt !== 16'd3) begin n_bad++; $display("FAIL raw_stall_cnt: got %0d want 3", bus.stall_cnt); end
        n_cmp++; if (bus.out_instr !== 27'h56 || bus.out_ra_a !== 4'd5) begin n_bad++; $display("FAIL raw_issued: got %0h a=%0d want 56 a=5", bus.out_instr, bus.out_ra_a); end
        offer(27'h57, 5, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL raw_pend5: got %0b want 1", bus.in_ready); end
        idle();
    endtask

    task automatic test_mem();
        offer(27'h100, 0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mem_first: got %0b want 1", bus.in_ready); end
        step();
        offer(27'h200, 1, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mem_busy0: got %0b want 0", bus.in_ready); end
        step();
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mem_busy1: got %0b want 0", bus.in_ready); end
        bus.mem_done = 1;
        step();
        bus.mem_done = 0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mem_free: got %0b want 1", bus.in_ready); end
        step();
        bus.out_ready = 0;
        offer(27'h300, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 27'h200 || bus.out_is_mem !== 1'b1 || bus.out_ra_a !== 4'd1) begin n_bad++; $display("FAIL mem_hold%0d: got v=%0b i=%0h m=%0b a=%0d want v=1 i=200 m=1 a=1", k, bus.out_valid, bus.out_instr, bus.out_is_mem, bus.out_ra_a); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mem_hold_ready%0d: got %0b want 0", k, bus.in_ready); end
            if (k < 2) step();
        end
        bus.out_ready = 1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mem_release: got %0b want 1", bus.in_ready); end
        step();
        idle();
        bus.mem_done = 1;
        step();
        idle();
    endtask

    task automatic test_jump();
        bus.redirect = 1;
        step();
        idle();
        offer(27'h400, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL jmp_run_redirect: got %0b want 1", bus.in_ready); end
        step();
        offer(27'h410, 0, 0, 0, 0, 0, 1, 0);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL jmp_accept: got %0b want 1", bus.in_ready); end
        step();
        offer(27'h420, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) bus.redirect = 1;
            #1;
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL jmp_wait%0d: got %0b want 0", k, bus.in_ready); end
            if (k == 1) begin
                n_cmp++; if (bus.out_is_jump !== 1'b1 || bus.out_instr !== 27'h410) begin n_bad++; $display("FAIL jmp_out: got j=%0b i=%0h want j=1 i=410", bus.out_is_jump, bus.out_instr); end
            end
            step();
        end
        bus.redirect = 0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL jmp_resume: got %0b want 1", bus.in_ready); end
        step();
        idle();
    endtask

    task automatic test_priv();
        step();
        bus.priv_in = 0;
        offer(27'h5A5A5A5, 0, 0, 0, 0, 0, 0, 1);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL priv_accept: got %0b want 1", bus.in_ready); end
        step();
        idle();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL priv_not_issued: got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.fault !== 1'b1 || bus.fault_instr !== 27'h5A5A5A5) begin n_bad++; $display("FAIL priv_fault: got f=%0b i=%0h want f=1 i=5a5a5a5", bus.fault, bus.fault_instr); end
        offer(27'h500, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL priv_block0: got %0b want 0", bus.in_ready); end
        step();
        bus.fault_ack = 1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL priv_block_ack: got %0b want 0", bus.in_ready); end
        step();
        bus.fault_ack = 0;
        #1;
        n_cmp++; if (bus.fault !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL priv_cleared: got f=%0b r=%0b want f=0 r=1", bus.fault, bus.in_ready); end
        step();
        bus.priv_in = 1;
        offer(27'h5A5A5A5, 0, 0, 0, 0, 0, 0, 1);
        step();
        idle();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 27'h5A5A5A5 || bus.fault !== 1'b0) begin n_bad++; $display("FAIL priv_ok: got v=%0b i=%0h f=%0b want v=1 i=5a5a5a5 f=0", bus.out_valid, bus.out_instr, bus.fault); end
        bus.priv_in = 0;
        step();
    endtask

    function automatic logic reg_busy(input logic [3:0] r);
        return r != 0 && pend_m[r] && !(bus.wb_valid && bus.wb_addr == r);
    endfunction

    function automatic logic model_ready();
        logic blocked;
        if (jwait_m || fault_m || !(held.size() == 0 || bus.out_ready)) return 1'b0;
        blocked = reg_busy(bus.dec_ra_a) || reg_busy(bus.dec_ra_b) || reg_busy(bus.dec_ra_m)
                  || reg_busy(bus.dec_ra_d) || (bus.dec_is_mem && busy_m);
        return (bus.dec_priv && !bus.priv_in) || !blocked;
    endfunction

    task automatic test_random();
        logic exp_ready;
        rec_t r;
        do_reset();
        foreach (pend_m[i]) pend_m[i] = 0;
        busy_m = 0; jwait_m = 0; fault_m = 0; finstr_m = '0; stall_m = 0;
        held.delete();
        for (int c = 0; c < 2000; c++) begin
            bus.in_valid = 1'($urandom_range(1));
            bus.in_instr = 27'($urandom);
            bus.dec_ra_a = 4'($urandom_range(7)); bus.dec_ra_b = 4'($urandom_range(7));
            bus.dec_ra_m = 4'($urandom_range(7)); bus.dec_ra_d = 4'($urandom_range(7));
            bus.dec_is_mem = ($urandom_range(3) == 0); bus.dec_is_jump = ($urandom_range(7) == 0);
            bus.dec_priv = ($urandom_range(7) == 0); bus.priv_in = 1'($urandom_range(1));
            bus.out_ready = ($urandom_range(3) != 0);
            bus.wb_valid = ($urandom_range(2) == 0); bus.wb_addr = 4'($urandom_range(7));
            bus.mem_done = ($urandom_range(3) == 0); bus.redirect = ($urandom_range(3) == 0);
            bus.fault_ack = ($urandom_range(3) == 0);
            #1;
            exp_ready = model_ready();
            n_cmp++; if (bus.in_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready@%0d: got %0b want %0b", c, bus.in_ready, exp_ready); end
            n_cmp++; if (bus.out_valid !== (held.size() != 0)) begin n_bad++; $display("FAIL rnd_valid@%0d: got %0b want %0b", c, bus.out_valid, held.size() != 0); end
            if (held.size() != 0) begin
                n_cmp++; if (bus.out_instr !== held[0].instr || bus.out_ra_a !== held[0].a || bus.out_ra_b !== held[0].b || bus.out_ra_m !== held[0].m || bus.out_ra_d !== held[0].d || bus.out_is_mem !== held[0].mem || bus.out_is_jump !== held[0].jump) begin
                    n_bad++; $display("FAIL rnd_out@%0d: got %0h want %0h", c, bus.out_instr, held[0].instr);
                end
            end
            n_cmp++; if (bus.fault !== fault_m || bus.fault_instr !== finstr_m) begin n_bad++; $display("FAIL rnd_fault@%0d: got %0b/%0h want %0b/%0h", c, bus.fault, bus.fault_instr, fault_m, finstr_m); end
            n_cmp++; if (bus.stall_cnt !== 16'(stall_m)) begin n_bad++; $display("FAIL rnd_stall@%0d: got %0d want %0d", c, bus.stall_cnt, stall_m); end
            @(posedge clk);
            if (bus.in_valid && !exp_ready) stall_m = (stall_m < 65535) ? stall_m + 1 : 65535;
            if (bus.wb_valid) pend_m[bus.wb_addr] = 0;
            if (bus.mem_done) busy_m = 0;
            if (jwait_m && bus.redirect) jwait_m = 0;
            if (fault_m && bus.fault_ack) fault_m = 0;
            if (held.size() != 0 && bus.out_ready) void'(held.pop_front());
            if (bus.in_valid && exp_ready) begin
                if (bus.dec_priv && !bus.priv_in) begin
                    fault_m = 1; finstr_m = bus.in_instr;
                end else begin
                    r.instr = bus.in_instr; r.a = bus.dec_ra_a; r.b = bus.dec_ra_b;
                    r.m = bus.dec_ra_m; r.d = bus.dec_ra_d; r.mem = bus.dec_is_mem; r.jump = bus.dec_is_jump;
                    held.push_back(r);
                    if (r.d != 0) pend_m[r.d] = 1;
                    if (r.mem) busy_m = 1;
                    if (r.jump) jwait_m = 1;
                end
            end
            #1;
        end
        idle();
    endtask

    task automatic test_saturate();
        do_reset();
        bus.out_ready = 0;
        offer(27'h1234567, 0, 0, 0, 9, 0, 0, 0);
        step();
        offer(27'h7654321, 9, 0, 0, 0, 0, 0, 0);
        repeat (70000) @(posedge clk);
        #1;
        n_cmp++; if (bus.stall_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_cnt: got %0h want ffff", bus.stall_cnt); end
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 27'h1234567 || bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL sat_held: got v=%0b i=%0h r=%0b want v=1 i=1234567 r=0", bus.out_valid, bus.out_instr, bus.in_ready); end
        rst_n = 0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 27'h0 || bus.out_ra_d !== 4'h0) begin n_bad++; $display("FAIL sat_rst_out: got v=%0b i=%0h d=%0h want 0", bus.out_valid, bus.out_instr, bus.out_ra_d); end
        n_cmp++; if (bus.stall_cnt !== 16'h0 || bus.fault !== 1'b0 || bus.fault_instr !== 27'h0) begin n_bad++; $display("FAIL sat_rst_misc: got s=%0h f=%0b fi=%0h want 0", bus.stall_cnt, bus.fault, bus.fault_instr); end
        idle();
        #2;
        rst_n = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_raw();
        test_mem();
        test_jump();
        test_priv();
        test_random();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

In-order issue controller between the instruction decoder and the execute/memory stages. Holds one decoded instruction in an output register and tracks outstanding register writes in a 16-entry scoreboard. Stalls on RAW/WAW hazards, a busy memory port or an unresolved jump, and traps privilege violations. This sequences the decoder's output into the datapath one instruction at a time.

## Interface
- `STALL_W`, 16: width of the saturating stall counter.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: decoded instruction offered.
- `in_ready` out 1: instruction accepted when `in_valid & in_ready`.
- `in_instr` in 27: raw instruction word.
- `dec_ra_a`, `dec_ra_b`, `dec_ra_m` in 4 each: source registers (0 = unused).
- `dec_ra_d` in 4: destination register (0 = none).
- `dec_is_mem` in 1: memory operation.
- `dec_is_jump` in 1: jump.
- `dec_priv` in 1: instruction requires privileged mode.
- `priv_in` in 1: current mode is privileged.
- `out_valid` out 1: issue register holds an instruction.
- `out_ready` in 1: downstream consumes when `out_valid & out_ready`.
- `out_instr` out 27: registered copy of `in_instr`.
- `out_ra_a`, `out_ra_b`, `out_ra_m`, `out_ra_d` out 4 each: registered copies of the decoded addresses.
- `out_is_mem`, `out_is_jump` out 1 each: registered copies of the decoded flags.
- `wb_valid` in 1: writeback completes this cycle.
- `wb_addr` in 4: register written back.
- `mem_done` in 1: outstanding memory operation finished.
- `redirect` in 1: jump target resolved; fetch redirected.
- `fault` out 1: privilege fault pending.
- `fault_instr` out 27: instruction that faulted.
- `fault_ack` in 1: clears the fault.
- `stall_cnt` out STALL_W: stall cycles, saturating.

## Operation
- States: RUN, JWAIT, FAULT.
- `pend[15:0]` scoreboard. Bit 0 is never set.
- `eff = pend & ~(wb_valid ? 1<<wb_addr : 0)`, so a writeback bypasses into the same-cycle hazard check.
- `hazard` = `eff` bit set for any nonzero `dec_ra_a`, `dec_ra_b`, `dec_ra_m` or `dec_ra_d`.
- `slot_free = !out_valid | out_ready`.
- `in_ready = (state==RUN) & slot_free & !hazard & !(dec_is_mem & mem_busy)`.
- Privilege-violating instructions (`dec_priv & ~priv_in`) bypass the hazard and mem checks. They are accepted when `state==RUN & slot_free`, are not issued, latch `fault_instr`, set `fault`, and move to FAULT.
- Normal accept:
  - Load the output register and set `out_valid`.
  - Set `pend[dec_ra_d]` if `dec_ra_d != 0`.
  - Set `mem_busy` if `dec_is_mem`.
  - Go to JWAIT if `dec_is_jump`.
- A consume without a simultaneous accept clears `out_valid`.
- `wb_valid` clears `pend[wb_addr]`. If an accept sets the same bit in the same cycle, the set wins.
- `mem_done` clears `mem_busy`. If an accept sets it in the same cycle, the set wins.
- JWAIT: `in_ready=0`. On `redirect`, return to RUN next cycle. `redirect` in RUN or FAULT is ignored.
- FAULT: `in_ready=0`, `fault=1`. On `fault_ack`, clear `fault` and return to RUN next cycle. Scoreboard and writebacks keep operating.
- `stall_cnt` increments each cycle `in_valid & !in_ready`. It saturates at all-ones.
- A privilege-violating accept counts as an accept, not a stall.

## Timing
- Reset values: `out_valid` 0, `fault` 0, all `out_*` 0, `fault_instr` 0, `stall_cnt` 0, `pend` 0, `mem_busy` 0, state RUN.
- An asynchronous reset mid-operation discards the held instruction and all pending state.
- Accept in cycle N gives `out_valid=1` in cycle N+1. Throughput is one instruction per cycle with no hazards and `out_ready` held high.
- `in_ready` is combinational from the `dec_*`, `wb_*` and `out_ready` inputs.
- A producer accepted in cycle N blocks consumers from cycle N+1. A dependent instruction is accepted in the same cycle its producer's `wb_valid` arrives.
- While `out_valid & !out_ready`, all output fields stay stable.
- A jump accepted in cycle N is followed by `in_ready=0` from cycle N+1 until the cycle after `redirect`.

## Test plan
- Reset, then 4 independent ALU instructions (`ra_d` = 1, 2, 3, 4) with `out_ready=1`:
  - Required: accepted in 4 consecutive cycles; `out_valid` high from cycle 1 for 4 cycles; `pend` = 0x001E; `stall_cnt` = 0.
- Instruction with `ra_d=5`, then a consumer with `ra_a=5`, and `wb_valid`/`wb_addr=5` asserted 3 cycles later:
  - Required: consumer stalls 3 cycles and is accepted in the `wb_valid` cycle; `stall_cnt` = 3; `pend[5]` = 0 afterwards.
- Two back-to-back loads, with `mem_done` 2 cycles after the first issue:
  - Required: second load waits until the `mem_done` cycle.
  - Then, with `out_ready=0` for 2 cycles, `out_*` stay unchanged and `in_ready` = 0.
- Jump followed by an ALU instruction, with `redirect` 4 cycles later:
  - Required: ALU instruction accepted 1 cycle after `redirect`.
  - Required: a `redirect` pulse in RUN has no effect.
- `dec_priv=1`, `priv_in=0`, `in_instr=0x5A5A5A5`:
  - Required: accepted with `out_valid` staying 0; `fault=1`; `fault_instr=0x5A5A5A5`; `in_ready=0` until the cycle after `fault_ack`.
  - Required: repeating with `priv_in=1` issues normally.
- Hold `in_valid` with a permanent hazard for 70000 cycles (STALL_W=16):
  - Required: `stall_cnt` = 0xFFFF.
  - Required: asserting `rst_n`=0 mid-run clears all outputs immediately.
